// File: rtl/arb_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_mux_pkg : shared constants and helpers for the arb_mux slice      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational rotating priority encoder, scan starts at base|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] base,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  // Scan from the farthest offset down so the slot nearest base wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      int pos;
      pos = int'(base) + k;
      if (pos >= NCH) pos = pos - NCH;
      if (req[pos]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_mux : N-channel valid/ready mux, fixed or round-robin selection,  |
// |           single registered output stage                              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;
  logic             r_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load_en;
  logic             w_fix_vld;
  logic [SELW-1:0]  w_fix_idx;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic [SELW-1:0]  w_rr_next;

  assign w_load_en = !r_valid || out_ready;

  // Equality against each legal index: out-of-range or unknown sel grants nothing.
  always_comb begin
    w_fix_vld = 1'b0;
    w_fix_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i) && in_valid[i]) begin
        w_fix_vld = 1'b1;
        w_fix_idx = SELW'(i);
      end
    end
  end

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (in_valid),
    .base    (r_rr_ptr),
    .gnt_vld (w_rr_vld),
    .gnt_idx (w_rr_idx)
  );

  assign w_gnt_vld = (mode == MODE_RR) ? w_rr_vld : w_fix_vld;
  assign w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : w_fix_idx;
  assign w_rr_next = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + SELW'(1);

  // rst_n gates ready directly: during reset load_en is forced true.
  always_comb begin
    in_ready = '0;
    if (rst_n && w_load_en && w_gnt_vld) in_ready[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_chan   <= '0;
      r_valid  <= 1'b0;
      r_rr_ptr <= '0;
    end else if (w_load_en) begin
      if (w_gnt_vld) begin
        r_data  <= in_data[w_gnt_idx*WIDTH +: WIDTH];
        r_chan  <= w_gnt_idx;
        r_valid <= 1'b1;
        if (mode == MODE_RR) r_rr_ptr <= w_rr_next;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arb_mux : self-checking bench, reference model for arb_mux         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [14:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [4:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;

  // reference model state (NCH=4 instance)
  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(8), .NCH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(5), .NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
  endfunction

  // Spec grant rule: fixed picks sel if valid; round-robin takes first valid from ptr.
  function automatic void model_pick(output bit gv, output int g);
    gv = 0; g = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < 4 && in_valid[sel]) begin gv = 1; g = int'(sel); end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (!gv && in_valid[idx]) begin gv = 1; g = idx; end
      end
    end
  endfunction

  // Check ready for the applied inputs, clock once, advance model, check outputs.
  task automatic step();
    bit gv; int g; bit load; logic [3:0] exp_rdy;
    #1;
    model_pick(gv, g);
    load = !m_valid || out_ready;
    exp_rdy = (gv && load) ? 4'(1 << g) : 4'b0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (load) begin
      if (gv) begin
        m_valid = 1;
        m_data  = in_data[g*8 +: 8];
        m_chan  = g;
        if (mode) m_ptr = (g + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
  endtask

  task automatic step3(input string tag, input bit exp_v, input int exp_c);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid3), 32'(exp_v));
    if (exp_v) chk({tag, "_chan"}, 32'(out_chan3), 32'(exp_c));
  endtask

  initial begin
    rst_n = 0; mode = 0; sel = 0; in_data = 0; in_valid = 4'hF; out_ready = 1;
    mode3 = 0; sel3 = 0; in_data3 = 0; in_valid3 = 0; out_ready3 = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // fixed select
    mode = 0; sel = 2; in_valid = 4'b0100; in_data = 32'h11A52233; out_ready = 1;
    step();
    chk("fix_data_a5", 32'(out_data), 32'hA5);
    sel = 3; in_valid = 4'b0100;
    step();

    // round-robin fairness, then sparse valids
    mode = 1; in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      step();
      chk("rr_seq", 32'(out_chan), 32'(i % 4));
    end
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      step();
      chk("rr_sparse", 32'(out_chan), (i % 2 == 0) ? 0 : 3);
    end

    // back-pressure
    mode = 0; sel = 1; in_valid = 4'b0010; in_data = 32'h00003C00; out_ready = 1;
    step();
    out_ready = 0; in_data = 32'h00005A00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", 32'(out_data), 32'h3C);
    end
    out_ready = 1;
    step();
    chk("bp_reload", 32'(out_data), 32'h5A);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom);
      in_data = $urandom; out_ready = ($urandom_range(3) != 0);
      step();
    end

    // reset mid-stream, asynchronous
    mode = 0; sel = 0; in_valid = 4'b0001; in_data = 32'h77; out_ready = 0;
    step();
    step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ready", 32'(in_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    mode = 1; in_valid = 4'hF; out_ready = 1; in_data = $urandom;
    step();
    chk("post_rst_chan0", 32'(out_chan), 0);

    // NCH=3, WIDTH=5 instance
    mode3 = 1; in_valid3 = 3'b111; in_data3 = 15'h7FFF;
    for (int i = 0; i < 6; i++) step3("odd_rr", 1, i % 3);
    mode3 = 0; sel3 = 2'd3;
    #1;
    chk("odd_sel3_ready", 32'(in_ready3), 0);
    step3("odd_sel3", 0, 0);
    sel3 = 2'bxx;
    #1;
    if ($isunknown(sel3)) chk("odd_selx_ready", 32'(in_ready3), 0);
    sel3 = 2'd2;
    #1;
    chk("odd_sel2_ready", 32'(in_ready3), 32'b100);
    step3("odd_sel2", 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
